// File: rtl/bist_pkg.sv
// Shared types and helpers for the link BIST engine: LFSR step, pattern
// expansion and the controller state encoding.
package bist_pkg;

    localparam logic [31:0] LFSR_POLY = 32'h80200003;

    // Widest channel bundle the pattern expander can produce.
    localparam int PAT_MAX = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2
    } bist_state_e;

    // One step of the right-shifting Galois LFSR, x^32+x^22+x^2+x+1.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

    // Alternating lfsr / ~lfsr 32-bit slices, bits at or above width forced to 0.
    function automatic logic [PAT_MAX-1:0] expand_pattern(input logic [31:0] lfsr,
                                                          input int          width);
        logic [PAT_MAX-1:0] rep;
        logic [PAT_MAX-1:0] keep;
        rep  = {(PAT_MAX / 64){~lfsr, lfsr}};
        keep = ~({PAT_MAX{1'b1}} << width);
        return rep & keep;
    endfunction

endpackage

// File: rtl/bist_delay_line.sv
// Fixed-latency shift register carrying {valid, pattern} from the transmit
// side to the compare point. DEPTH of 0 is a plain wire.
module bist_delay_line #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ reset;
            assign dout           = din;
        end else begin : g_shift
            logic [WIDTH-1:0] stage_q [DEPTH];
            logic [WIDTH-1:0] stage_d [DEPTH];

            // Stage 0 takes the new entry, every other stage its predecessor.
            always_comb begin
                stage_d[0] = din;
                for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
            end

            // Shift register; reset empties it so no stale valid reaches compare.
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
                end else begin
                    stage_q <= stage_d;
                end
            end

            assign dout = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/bist_link_tester.sv
// Link BIST engine: transmits TEST_CASES LFSR vectors, checks the looped-back
// return LOOP_LATENCY cycles later, keeps per-channel fault mask and error
// count, then falls back to mission-mode pass-through.
// Optional build macro BIST_ERR_INJECT_EN adds an 'inject' input that flips
// channel 0 on the wire (not in the reference copy) during SEND.
//
//   state | meaning
//   IDLE  | pass-through, results held, waiting for start
//   SEND  | driving pattern vectors, one per cycle
//   DRAIN | line driven low, waiting for the last vectors to return
module bist_link_tester
    import bist_pkg::*;
#(
    parameter int          TEST_CHANNELS = 70,
    parameter logic [31:0] SEED          = 32'hdeadbeef,
    parameter int          TEST_CASES    = 1000,
    parameter int          LOOP_LATENCY  = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
`ifdef BIST_ERR_INJECT_EN
    input  logic                                inject,
`endif
    input  logic [TEST_CHANNELS-1:0]            input_channels,
    output logic [TEST_CHANNELS-1:0]            output_channels,
    output logic                                busy,
    output logic                                done,
    output logic                                pass,
    output logic [TEST_CHANNELS-1:0]            fail_mask,
    output logic [$clog2(TEST_CASES+1)-1:0]     error_count
);

    localparam int               CNT_W      = $clog2(TEST_CASES + 1);
    localparam logic [31:0]      SEED_EFF   = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [CNT_W-1:0] TX_LAST    = CNT_W'(TEST_CASES - 1);
    localparam logic [CNT_W-1:0] ERR_MAX    = CNT_W'(TEST_CASES);
    localparam logic [3:0]       DRAIN_LAST = 4'((LOOP_LATENCY > 0) ? LOOP_LATENCY - 1 : 0);

    bist_state_e                state_q, state_d;
    logic [31:0]                lfsr_q, lfsr_d;
    logic [CNT_W-1:0]           tx_cnt_q, tx_cnt_d;
    logic [3:0]                 drain_cnt_q, drain_cnt_d;
    logic [TEST_CHANNELS-1:0]   fail_mask_q, fail_mask_d;
    logic [CNT_W-1:0]           error_count_q, error_count_d;
    logic                       pass_q, pass_d;
    logic                       done_q, done_d;

    logic [TEST_CHANNELS-1:0]   pattern;
    logic [TEST_CHANNELS-1:0]   diff;
    logic [TEST_CHANNELS:0]     dl_in, dl_out;

    bist_delay_line #(
        .DEPTH (LOOP_LATENCY),
        .WIDTH (TEST_CHANNELS + 1)
    ) u_delay (
        .clk   (clk),
        .reset (reset),
        .din   (dl_in),
        .dout  (dl_out)
    );

    // Next-state, counters, compare accumulation and the output mux.
    always_comb begin
        state_d         = state_q;
        lfsr_d          = lfsr_q;
        tx_cnt_d        = tx_cnt_q;
        drain_cnt_d     = drain_cnt_q;
        fail_mask_d     = fail_mask_q;
        error_count_d   = error_count_q;
        pass_d          = pass_q;
        done_d          = 1'b0;
        dl_in           = '0;
        output_channels = input_channels;
        pattern         = TEST_CHANNELS'(expand_pattern(lfsr_q, TEST_CHANNELS));
        diff            = input_channels ^ dl_out[TEST_CHANNELS-1:0];

        if (dl_out[TEST_CHANNELS]) begin
            fail_mask_d = fail_mask_q | diff;
            if ((diff != '0) && (error_count_q != ERR_MAX)) begin
                error_count_d = error_count_q + CNT_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d       = SEND;
                    lfsr_d        = SEED_EFF;
                    tx_cnt_d      = TX_LAST;
                    fail_mask_d   = '0;
                    error_count_d = '0;
                    pass_d        = 1'b0;
                end
            end
            SEND: begin
                output_channels = pattern;
`ifdef BIST_ERR_INJECT_EN
                output_channels[0] = pattern[0] ^ inject;
`endif
                dl_in  = {1'b1, pattern};
                lfsr_d = lfsr_next(lfsr_q);
                if (tx_cnt_q == '0) begin
                    if (LOOP_LATENCY > 0) begin
                        state_d     = DRAIN;
                        drain_cnt_d = DRAIN_LAST;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        pass_d  = (error_count_d == '0);
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - CNT_W'(1);
                end
            end
            DRAIN: begin
                output_channels = '0;
                if (drain_cnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    pass_d  = (error_count_d == '0);
                end else begin
                    drain_cnt_d = drain_cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers; reset launches a fresh run immediately.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= SEND;
            lfsr_q        <= SEED_EFF;
            tx_cnt_q      <= TX_LAST;
            drain_cnt_q   <= '0;
            fail_mask_q   <= '0;
            error_count_q <= '0;
            pass_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            tx_cnt_q      <= tx_cnt_d;
            drain_cnt_q   <= drain_cnt_d;
            fail_mask_q   <= fail_mask_d;
            error_count_q <= error_count_d;
            pass_q        <= pass_d;
            done_q        <= done_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail_mask   = fail_mask_q;
    assign error_count = error_count_q;

endmodule
